// File: rtl/col_parity_theta_decoder_pkg.sv
// Shared types, widths and lane/column index helpers for the column-parity
// (theta) decoder.
//   SLICE_W   : bits per 5x5 slice
//   COL_W     : bits per column-parity vector
//   DEPTH_DEF : default slices per state
//   IDXW_DEF  : default depth index width, equal to clog2(DEPTH_DEF)
// Bit order: lane (x,y) sits at slice bit 24-(x+5y); the parity of column x
// sits at parity-vector bit 4-x.
package col_parity_theta_decoder_pkg;

  localparam int unsigned SLICE_W   = 25;
  localparam int unsigned COL_W     = 5;
  localparam int unsigned DEPTH_DEF = 64;
  localparam int unsigned IDXW_DEF  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // One buffered input beat: encoded slice plus the original slice's parities
  typedef struct packed {
    logic [SLICE_W-1:0] slice;
    logic [COL_W-1:0]   par;
  } beat_t;

  // Slice bit position of lane (x,y)
  function automatic logic [4:0] lane_bit(int unsigned x, int unsigned y);
    return 5'(24 - (x + 5 * y));
  endfunction

  // Parity-vector bit position of column x
  function automatic logic [2:0] col_bit(int unsigned x);
    return 3'(4 - x);
  endfunction

endpackage

// File: rtl/col_parity_theta_undo.sv
// Combinational theta inverse for one slice.
//   slice     : encoded slice a'[z]
//   par_cur   : column parities C[z] of the original slice
//   par_prev  : column parities C[z-1] (wrapped)
//   slice_out : decoded slice a[z]
//   par_out   : column parities of slice_out (consumed by the optional checker)
module col_parity_theta_undo
  import col_parity_theta_decoder_pkg::*;
(
  input  logic [SLICE_W-1:0] slice,
  input  logic [COL_W-1:0]   par_cur,
  input  logic [COL_W-1:0]   par_prev,
  output logic [SLICE_W-1:0] slice_out,
  output logic [COL_W-1:0]   par_out
);

  logic [COL_W-1:0] col_mask;

  // Per-column flip: left neighbour in this slice, right neighbour in the previous one
  always_comb begin
    col_mask = '0;
    for (int unsigned x = 0; x < 5; x++) begin
      col_mask[col_bit(x)] = par_cur[col_bit((x + 4) % 5)] ^ par_prev[col_bit((x + 1) % 5)];
    end
  end

  // Apply the column mask to every row and recompute the resulting column parities
  always_comb begin
    slice_out = slice;
    par_out   = '0;
    for (int unsigned x = 0; x < 5; x++) begin
      for (int unsigned y = 0; y < 5; y++) begin
        slice_out[lane_bit(x, y)] = slice[lane_bit(x, y)] ^ col_mask[col_bit(x)];
        par_out[col_bit(x)]       = par_out[col_bit(x)] ^ slice_out[lane_bit(x, y)];
      end
    end
  end

endmodule

// File: rtl/col_parity_theta_decoder.sv
// Column-parity (theta) decoder: buffers one full 5x5xDEPTH state streamed as
// slices with their column-parity vectors, then emits the decoded slices in z
// order with valid/ready handshaking.
// Optional feature macro: PARITY_CHECK_EN -- recompute the decoded slice's
// column parities and flag m_err when they differ from the supplied C[z].
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   s_valid/s_ready         input handshake
//   s_slice, s_par          encoded slice a'[z] and original parities C[z]
//   m_valid/m_ready         output handshake
//   m_slice, m_depth        decoded slice a[z] and its z
//   m_last                  marks z = DEPTH-1
//   m_err                   parity mismatch on this beat (0 without the macro)
module col_parity_theta_decoder
  import col_parity_theta_decoder_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned IDXW  = IDXW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SLICE_W-1:0] s_slice,
  input  logic [COL_W-1:0]   s_par,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [SLICE_W-1:0] m_slice,
  output logic [IDXW-1:0]    m_depth,
  output logic               m_last,
  output logic               m_err
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [IDXW-1:0]    wr_idx_q, wr_idx_d;
  logic [IDXW-1:0]    rd_idx_q, rd_idx_d;
  logic               rd_done_q, rd_done_d;
  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic [SLICE_W-1:0] m_slice_q, m_slice_d;
  logic [IDXW-1:0]    m_depth_q, m_depth_d;
  logic               m_last_q, m_last_d;
  logic               m_err_q, m_err_d;

  logic               wr_en;
  logic [IDXW-1:0]    wr_addr;
  beat_t              mem_q [DEPTH];

  logic [IDXW-1:0]    prev_idx;
  beat_t              cur_beat, prev_beat;
  logic [SLICE_W-1:0] dec_slice;
  logic [COL_W-1:0]   dec_par;
  logic               err_c;
  logic               s_xfer, m_xfer;

  assign s_xfer = s_valid & s_ready_q;
  assign m_xfer = m_valid_q & m_ready;

  // z=0 pairs with the last slice of the state (wrap)
  assign prev_idx  = (rd_idx_q == '0) ? LAST_IDX : rd_idx_q - 1'b1;
  assign cur_beat  = mem_q[rd_idx_q];
  assign prev_beat = mem_q[prev_idx];

  col_parity_theta_undo u_undo (
    .slice     (cur_beat.slice),
    .par_cur   (cur_beat.par),
    .par_prev  (prev_beat.par),
    .slice_out (dec_slice),
    .par_out   (dec_par)
  );

`ifdef PARITY_CHECK_EN
  assign err_c = (dec_par != cur_beat.par);
`else
  logic unused_par;
  assign unused_par = ^dec_par;
  assign err_c      = 1'b0;
`endif

  // Next-state, counters and output-register loads
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    rd_done_d = rd_done_q;
    m_valid_d = m_valid_q;
    m_slice_d = m_slice_q;
    m_depth_d = m_depth_q;
    m_last_d  = m_last_q;
    m_err_d   = m_err_q;
    wr_en     = 1'b0;
    wr_addr   = wr_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (s_xfer) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_idx_d = IDXW'(1);
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (s_xfer) begin
          wr_en = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d  = '0;
            rd_idx_d  = '0;
            rd_done_d = 1'b0;
            state_d   = ST_EMIT;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (m_xfer) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            state_d = ST_IDLE;
          end
        end
        // Refill the output register when it is empty or draining this cycle
        if (!rd_done_q && (!m_valid_q || m_ready)) begin
          m_valid_d = 1'b1;
          m_slice_d = dec_slice;
          m_depth_d = rd_idx_q;
          m_last_d  = (rd_idx_q == LAST_IDX);
          m_err_d   = err_c;
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d  = '0;
            rd_done_d = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d = (state_d != ST_EMIT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      rd_done_q <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_slice_q <= '0;
      m_depth_q <= '0;
      m_last_q  <= 1'b0;
      m_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      rd_done_q <= rd_done_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_slice_q <= m_slice_d;
      m_depth_q <= m_depth_d;
      m_last_q  <= m_last_d;
      m_err_q   <= m_err_d;
    end
  end

  // State buffer; contents are only read after a complete load, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= '{slice: s_slice, par: s_par};
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_slice = m_slice_q;
  assign m_depth = m_depth_q;
  assign m_last  = m_last_q;
  assign m_err   = m_err_q;

endmodule

// File: tb/tb_col_parity_theta_decoder.sv
// Testbench for col_parity_theta_decoder: a software theta encoder builds each
// streamed state; expected decoded beats go into a scoreboard queue and are
// compared as the decoder hands them out.
module tb_col_parity_theta_decoder;

  localparam int D = 64;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [24:0] s_slice;
  logic [4:0]  s_par;
  logic        m_valid;
  logic        m_ready;
  logic [24:0] m_slice;
  logic [5:0]  m_depth;
  logic        m_last;
  logic        m_err;

  col_parity_theta_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_slice (s_slice),
    .s_par   (s_par),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_slice (m_slice),
    .m_depth (m_depth),
    .m_last  (m_last),
    .m_err   (m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] slice;
    logic [5:0]  depth;
    logic        last;
    logic        err;
  } exp_t;

  typedef struct {
    int kind;       // 0 zero, 1 single lane (0,0,0), 2 random, 3 all ones
    int ready_pct;  // m_ready duty during EMIT
    bit hold;       // keep s_valid high with junk during EMIT
    bit corrupt;    // flip s_par[20] bit 2
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[6];
  logic [24:0] orig [D];
  logic [24:0] enc  [D];
  logic [4:0]  cp   [D];
  logic [4:0]  cu   [D];
  int          ncmp = 0;
  int          nfail = 0;

  function automatic logic [4:0] lb(int x, int y);
    return 5'(24 - (x + 5 * y));
  endfunction

  function automatic logic [2:0] cb(int x);
    return 3'(4 - x);
  endfunction

  function automatic logic [4:0] colpar(logic [24:0] s);
    logic [4:0] p;
    p = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        p[cb(x)] = p[cb(x)] ^ s[lb(x, y)];
    return p;
  endfunction

  // a ^ C[z][x-1] ^ C[z-1][x+1]; its own inverse when C is the original parity
  function automatic logic [24:0] theta(logic [24:0] s, logic [4:0] c, logic [4:0] cprev);
    logic [24:0] r;
    logic        m;
    r = s;
    for (int x = 0; x < 5; x++) begin
      m = c[cb((x + 4) % 5)] ^ cprev[cb((x + 1) % 5)];
      for (int y = 0; y < 5; y++) r[lb(x, y)] = s[lb(x, y)] ^ m;
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fill_state(int kind);
    for (int z = 0; z < D; z++) begin
      case (kind)
        0:       orig[z] = '0;
        1:       orig[z] = (z == 0) ? 25'h1000000 : 25'h0;
        3:       orig[z] = '1;
        default: orig[z] = 25'($urandom());
      endcase
    end
  endtask

  task automatic encode_state(bit corrupt);
    for (int z = 0; z < D; z++) cp[z] = colpar(orig[z]);
    for (int z = 0; z < D; z++) begin
      enc[z] = theta(orig[z], cp[z], cp[(z + D - 1) % D]);
      cu[z]  = cp[z];
    end
    if (corrupt) cu[20][2] = ~cu[20][2];
  endtask

  // Stream n beats; leaves s_valid high with junk when hold is set
  task automatic send_beats(int n, bit hold);
    int w;
    for (int z = 0; z < n; z++) begin
      s_valid = 1'b1;
      s_slice = enc[z];
      s_par   = cu[z];
      w = 0;
      while (!s_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!s_ready) chk("s_ready_timeout", 32'(z), 32'(-1));
      @(negedge clk);
    end
    if (hold) begin
      s_slice = 25'($urandom());
      s_par   = 5'($urandom());
    end else begin
      s_valid = 1'b0;
    end
  endtask

  task automatic collect(int ready_pct);
    int   got, cyc;
    bit   r, stalled;
    exp_t e, held;
    got = 0; cyc = 0; stalled = 0;
    while (got < D && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk("hold_valid", 32'(m_valid), 32'(1));
        chk("hold_slice", 32'(m_slice), 32'(held.slice));
        chk("hold_depth", 32'(m_depth), 32'(held.depth));
      end
      r = (int'($urandom_range(99)) < ready_pct);
      stalled = 0;
      if (m_valid) begin
        chk("s_ready_in_emit", 32'(s_ready), 32'(0));
        if (r) begin
          e = sbq.pop_front();
          chk("m_slice", 32'(m_slice), 32'(e.slice));
          chk("m_depth", 32'(m_depth), 32'(e.depth));
          chk("m_last",  32'(m_last),  32'(e.last));
          chk("m_err",   32'(m_err),   32'(e.err));
          got++;
        end else begin
          stalled = 1;
          held.slice = m_slice;
          held.depth = m_depth;
        end
      end
      m_ready = r;
    end
    if (got < D) chk("emit_timeout_beats", 32'(got), 32'(D));
    @(negedge clk);
    m_ready = 1'b0;
    chk("m_valid_after_last", 32'(m_valid), 32'(0));
    chk("s_ready_after_last", 32'(s_ready), 32'(1));
    s_valid = 1'b0;
  endtask

  task automatic run_state(int kind, int ready_pct, bit hold, bit corrupt);
    logic [24:0] d;
    logic        e;
    sbq.delete();
    fill_state(kind);
    encode_state(corrupt);
    for (int z = 0; z < D; z++) begin
      if (corrupt) begin
        d = theta(enc[z], cu[z], cu[(z + D - 1) % D]);
`ifdef PARITY_CHECK_EN
        e = (colpar(d) != cu[z]);
`else
        e = 1'b0;
`endif
      end else begin
        d = orig[z];
        e = 1'b0;
      end
      sbq.push_back('{slice: d, depth: 6'(z), last: (z == D - 1), err: e});
    end
    fork
      send_beats(D, hold);
      collect(ready_pct);
    join
  endtask

  initial begin
    tbl[0] = '{kind: 0, ready_pct: 100, hold: 1'b0, corrupt: 1'b0};
    tbl[1] = '{kind: 1, ready_pct: 100, hold: 1'b0, corrupt: 1'b0};
    tbl[2] = '{kind: 2, ready_pct: 100, hold: 1'b0, corrupt: 1'b0};
    tbl[3] = '{kind: 2, ready_pct: 30,  hold: 1'b1, corrupt: 1'b0};
    tbl[4] = '{kind: 3, ready_pct: 50,  hold: 1'b0, corrupt: 1'b0};
    tbl[5] = '{kind: 2, ready_pct: 100, hold: 1'b0, corrupt: 1'b1};

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_slice = '0;
    s_par   = '0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'(0));
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_m_slice", 32'(m_slice), 32'(0));
    chk("rst_m_depth", 32'(m_depth), 32'(0));
    chk("rst_m_last",  32'(m_last),  32'(0));
    chk("rst_m_err",   32'(m_err),   32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", 32'(s_ready), 32'(1));

    for (int i = 0; i < 6; i++)
      run_state(tbl[i].kind, tbl[i].ready_pct, tbl[i].hold, tbl[i].corrupt);

    // Reset in the middle of a load, then a fresh state must decode cleanly
    fill_state(3);
    encode_state(1'b0);
    send_beats(37, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_m_valid", 32'(m_valid), 32'(0));
    chk("midrst_s_ready", 32'(s_ready), 32'(0));
    chk("midrst_m_depth", 32'(m_depth), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle_s_ready", 32'(s_ready), 32'(1));
    run_state(2, 70, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
